// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two requesters, the shared 128-word data memory
// and dmem_arbiter. The arbiter uses the slave view; requesters/memory the master view.
interface dmem_arbiter_if;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, busy;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, stall0, busy,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, stall0, busy,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the shared data memory: one access in
// flight, one-cycle strobe, MEM_LAT wait cycles, one-cycle done pulse.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic        busy_q, busy_d;
  logic        launch, win, capture;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    port_d      = port_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    launch      = 1'b0;
    win         = 1'b0;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          launch = 1'b1;
          win    = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
        end
      end
      ACCESS: begin
        ptr_d = ~port_q;
        if (MEM_LAT == 0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // The completing port is masked so a waiting peer is served without an IDLE bubble.
        state_d = IDLE;
        if (port_q ? bus.req0 : bus.req1) begin
          launch = 1'b1;
          win    = ~port_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d     = ACCESS;
      port_d      = win;
      we_d        = win ? bus.we1 : bus.we0;
      mem_addr_d  = win ? bus.addr1 : bus.addr0;
      mem_wdata_d = win ? bus.wdata1 : bus.wdata0;
    end

    if (capture && !we_q) begin
      if (port_q) rdata1_d = bus.mem_rdata;
      else        rdata0_d = bus.mem_rdata;
    end

    gnt0_d   = (state_d == ACCESS) && !port_d;
    gnt1_d   = (state_d == ACCESS) &&  port_d;
    done0_d  = (state_d == RESP)   && !port_d;
    done1_d  = (state_d == RESP)   &&  port_d;
    mem_re_d = (state_d == ACCESS) && !we_d;
    mem_we_d = (state_d == ACCESS) &&  we_d;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      port_q      <= port_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.stall0    = bus.req0 & ~done0_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared 128-word data memory. It sits between the core memory stage (port 0) and a program-loader/debug port (port 1). It serialises their requests with round-robin priority, drives the memory's read/write strobes for exactly one cycle per access, and waits a configurable memory latency. It returns read data with a one-cycle `done` pulse and stalls the core while its access is pending.

## Interface
- `MEM_LAT`, default 0: memory read latency in cycles after the strobe cycle; legal range 0..15. 0 means combinational read, matching the current data memory.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-low.
- `req0`, `req1`  in  1  access request. Held high until `doneX` is seen.
- `we0`, `we1`  in  1  1 = write, 0 = read. Stable while `reqX` is high.
- `addr0`, `addr1`  in  32  byte address. Passed through unmodified.
- `wdata0`, `wdata1`  in  32  write data.
- `gnt0`, `gnt1`  out  1  one-cycle pulse. High in the strobe (ACCESS) cycle of that port's access.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  32  registered read data. Valid from the `doneX` cycle and held until that port's next read completes.
- `stall0`  out  1  combinational; equals `req0 & ~done0`. Feeds the core PC/pipeline hold.
- `busy`  out  1  high in any state other than IDLE.
- `mem_re`, `mem_we`  out  1  memory strobes. At most one is high, for exactly one cycle per access.
- `mem_addr`, `mem_wdata`  out  32  latched address and write data of the access in progress.
- `mem_rdata`  in  32  memory read data.

## Operation
- States: IDLE, ACCESS, WAIT, RESP. `cnt` is 4 bits. `ptr` is 1 bit and names the port with priority on a tie.
- **IDLE**
  - If exactly one `reqX` is high, that port wins. If both are high, port `ptr` wins.
  - Latch the winner's `we`, `addr`, `wdata` and port id. Go to ACCESS.
  - If no request, stay in IDLE.
- **ACCESS** (one cycle)
  - `gntW` = 1; `mem_we` = latched `we`; `mem_re` = ~latched `we`.
  - `ptr` ← the other port.
  - If `MEM_LAT` = 0: capture `mem_rdata` (reads only), go to RESP.
  - Else: `cnt` ← `MEM_LAT`, go to WAIT.
- **WAIT**
  - `cnt` ← `cnt` − 1. All strobes low.
  - When `cnt` = 1, capture `mem_rdata` (reads only) and go to RESP.
  - WAIT therefore lasts exactly `MEM_LAT` cycles.
- **RESP** (one cycle)
  - `doneW` = 1. `rdataW` is updated (reads only); on writes `rdataW` keeps its old value.
  - Arbitrate again with the completing port's request masked. If the other port is requesting, latch it and go straight to ACCESS; otherwise go to IDLE.
- Each access completes in order. There is only ever one access in flight.
- If a requester drops `req` before `done`, this is a protocol violation. The access still completes and `done` still pulses.
- Changes to `addr`, `we` or `wdata` after the IDLE/RESP latch cycle are ignored.

## Timing
- Reset (`rst` low at a clock edge) sets:
  - state to IDLE, `ptr` to 0, `cnt` to 0;
  - `gnt*`, `done*`, `mem_re`, `mem_we`, `busy` to 0;
  - `mem_addr`, `mem_wdata`, `rdata0`, `rdata1` to 0.
- Reset mid-operation abandons the access with no `done`. A write whose ACCESS edge has already occurred stays committed in memory.
- Single-request latency: `req` is high in IDLE at cycle N. ACCESS is at N+1, WAIT runs N+2 .. N+1+`MEM_LAT`, and `done` is at N+2+`MEM_LAT`.
- Back-to-back contention: one access per 2+`MEM_LAT` cycles; there is no IDLE bubble between the ports.
- A port re-requesting immediately after its own `done`:
  - If the other port is pending, the other port is served first.
  - Otherwise the arbiter passes through IDLE, giving that port 3+`MEM_LAT` cycles per access.
- Outputs are registered except `stall0`.
- `mem_addr` and `mem_wdata` are stable from ACCESS through RESP.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `req0`=`req1`=1 → all outputs 0 and no strobe. Release → `gnt0` is asserted first because `ptr` resets to 0.
- **Single read, MEM_LAT=0:** `req0`=1, `we0`=0, `addr0`=0x10, memory holds 4 at word 4 → `mem_re` high at N+1 only, `done0` and `rdata0`=4 at N+2. `stall0` is high during N..N+1 and low at N+2.
- **Single write, MEM_LAT=3:** `req1` writes 0xDEADBEEF to `addr1`=0x20 → `mem_we` high for exactly 1 cycle at N+1, `done1` at N+5, `rdata1` unchanged.
- **Contention, MEM_LAT=0:** `req0` and `req1` rise together, both held → `gnt0` at N+1, `done0` at N+2, `gnt1` at N+3, `done1` at N+4. `mem_re`/`mem_we` are never high in the same cycle.
- **Round-robin fairness:** both ports request continuously for 8 accesses → grants alternate 0,1,0,1,…, with no port granted twice in a row.
- **Reset mid-WAIT, MEM_LAT=4:** start a read, assert `rst` during the 2nd WAIT cycle → no `done`, state returns to IDLE. A new request after reset completes normally.
